// File: rtl/sm_step_gen.sv
// sm_step_gen -- PIO state-machine step enable generator.
//
// Turns the fractional clock divider's pclk square wave into single-cycle
// step enables in the clk domain. It also swallows the steps requested by an
// instruction's [delay] field before the state machine may execute again.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   pclk        divider output (square wave, synchronous to clk)
//   bypass      divider set to exactly 1.0: issue a step every enabled cycle
//   en          state machine enable; while low, ticks stop and the delay holds
//   restart     single-cycle pulse, clears step and delay state
//   done        instruction completed (not stalled) in the current exec_en cycle
//   delay       delay field of the instruction completing with done
//   tick        registered step pulse
//   exec_en     tick while not delaying; the state machine acts only in this cycle
//   delaying    a delay is being swallowed
//   delay_cnt   remaining delay steps
//   exec_count  (SM_STEP_STATS_EN only) completed instruction count
//   stall_count (SM_STEP_STATS_EN only) stalled exec_en cycle count
//
// Optional feature macro: SM_STEP_STATS_EN adds the exec/stall counters.
module sm_step_gen #(
  parameter int DELAY_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pclk,
  input  logic               bypass,
  input  logic               en,
  input  logic               restart,
  input  logic               done,
  input  logic [DELAY_W-1:0] delay,
  output logic               tick,
  output logic               exec_en,
  output logic               delaying,
  output logic [DELAY_W-1:0] delay_cnt
`ifdef SM_STEP_STATS_EN
  ,
  output logic [31:0]        exec_count,
  output logic [31:0]        stall_count
`endif
);

  localparam logic [DELAY_W-1:0] CNT_ZERO = {DELAY_W{1'b0}};
  localparam logic [DELAY_W-1:0] CNT_ONE  = DELAY_W'(1'b1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DELAY = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               pclk_d_r;
  logic               tick_r;
  logic               tick_nxt_s;
  logic               exec_en_s;
  logic [DELAY_W-1:0] delay_cnt_r;
  logic [DELAY_W-1:0] delay_cnt_nxt_s;

  // Rising-edge detect on pclk, or a step every cycle when the divider is 1.0.
  always_comb begin
    tick_nxt_s = en & (bypass | (pclk & ~pclk_d_r));
  end

  // Execution is only allowed on a step taken outside a delay.
  always_comb begin
    exec_en_s = tick_r & (state_r == ST_RUN);
  end

  // Next state / remaining delay; DELAY is only entered with a nonzero count,
  // so the decrement can never wrap below zero.
  always_comb begin
    state_nxt_s     = state_r;
    delay_cnt_nxt_s = delay_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (exec_en_s && done && (delay != CNT_ZERO)) begin
          state_nxt_s     = ST_DELAY;
          delay_cnt_nxt_s = delay;
        end else begin
          state_nxt_s     = ST_RUN;
          delay_cnt_nxt_s = delay_cnt_r;
        end
      end
      ST_DELAY: begin
        if (tick_r) begin
          delay_cnt_nxt_s = delay_cnt_r - CNT_ONE;
          if (delay_cnt_r == CNT_ONE) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_DELAY;
          end
        end else begin
          state_nxt_s     = ST_DELAY;
          delay_cnt_nxt_s = delay_cnt_r;
        end
      end
      default: begin
        state_nxt_s     = ST_RUN;
        delay_cnt_nxt_s = CNT_ZERO;
      end
    endcase
  end

  // Step/delay registers; restart clears exactly like reset so the divider
  // and the step logic start from a common point.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_RUN;
      delay_cnt_r <= CNT_ZERO;
      tick_r      <= 1'b0;
      pclk_d_r    <= 1'b0;
    end else if (restart) begin
      state_r     <= ST_RUN;
      delay_cnt_r <= CNT_ZERO;
      tick_r      <= 1'b0;
      pclk_d_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      delay_cnt_r <= delay_cnt_nxt_s;
      tick_r      <= tick_nxt_s;
      pclk_d_r    <= pclk;
    end
  end

  assign tick      = tick_r;
  assign exec_en   = exec_en_s;
  assign delaying  = (state_r == ST_DELAY);
  assign delay_cnt = delay_cnt_r;

`ifdef SM_STEP_STATS_EN
  logic [31:0] exec_count_r;
  logic [31:0] stall_count_r;

  // Free-running (wrapping) completed and stalled instruction counters.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      exec_count_r  <= 32'd0;
      stall_count_r <= 32'd0;
    end else if (exec_en_s) begin
      if (done) begin
        exec_count_r <= exec_count_r + 32'd1;
      end else begin
        stall_count_r <= stall_count_r + 32'd1;
      end
    end else begin
      exec_count_r  <= exec_count_r;
      stall_count_r <= stall_count_r;
    end
  end

  assign exec_count  = exec_count_r;
  assign stall_count = stall_count_r;
`endif

endmodule
